fb_port_arbiter: RTL

Shares one single-port synchronous framebuffer RAM between the display readout path and the game-logic pixel writer inside `game_console`. The display read has absolute priority. It fetches one framebuffer word per 4×4 screen block, so the port is free 3 of every 4 active cycles and on every blanking cycle. Writes are queued in a small FIFO and retired in the free slots. The block drives `monitor_r/g/b` with a fixed 2-cycle latency relative to the `display_ctrl` coordinates.

---
 rtl/fb_pkg.sv | 36 +++
 rtl/fb_port_arbiter_if.sv | 24 ++
 rtl/fb_wr_fifo.sv | 61 ++++++
 rtl/fb_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer port arbiter: pixel format,
// clear-engine states, grant encoding and the display read-address helper.
package fb_pkg;

  localparam int FB_W_DEF       = 200;
  localparam int FB_H_DEF       = 150;
  localparam int SCALE_LOG2_DEF = 2;
  localparam int ADDR_W_DEF     = 15;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_DRAIN = 2'd1,
    CLR_CLEAR = 2'd2
  } clr_state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_CLEAR = 2'd2,
    GNT_FIFO  = 2'd3
  } gnt_t;

  // Framebuffer word covering screen pixel (h,v); callers truncate to their address width.
  function automatic logic [31:0] fb_read_addr(input logic [10:0] h, input logic [9:0] v,
                                               input int fb_w, input int scale_log2);
    return 32'(v >> scale_log2) * 32'(fb_w) + 32'(h >> scale_log2);
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Writer handshake plus single-port framebuffer RAM bus. The arbiter takes the
// slave view; the game logic / RAM side takes the master view.
interface fb_port_arbiter_if import fb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  rgb444_t           wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  rgb444_t           mem_wdata;
  rgb444_t           mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding queued pixel writes. Push while full is accepted
// only when a pop happens in the same cycle.
module fb_wr_fifo import fb_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int             PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]    C_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == C_FULL);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rptr];

  // Entry storage
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: display reads take priority, queued pixel writes
// retire in the free slots. Define FB_CLEAR_EN to add the full-screen clear engine.
module fb_port_arbiter import fb_pkg::*; #(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [10:0]         h_coord,
  input  logic [9:0]          v_coord,
  input  logic                disp_enbl,
`ifdef FB_CLEAR_EN
  input  logic                clear_req,
  input  logic [11:0]         clear_color,
  output logic                clear_busy,
`endif
  fb_port_arbiter_if.slave    bus,
  output logic [3:0]          pix_r,
  output logic [3:0]          pix_g,
  output logic [3:0]          pix_b,
  output logic                pix_de
);

  localparam int FB_WORDS = FB_W * FB_H;
  localparam int ENTRY_W  = ADDR_W + 12;

  logic               w_rd_slot;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ENTRY_W-1:0] w_fifo_dout;
  logic [ADDR_W-1:0]  w_head_addr;
  rgb444_t            w_head_data;
  logic               w_head_ok;
  gnt_t               w_gnt;
  logic               w_clr_active;
  logic [ADDR_W-1:0]  w_clr_addr;
  rgb444_t            w_clr_data;
  logic               w_wr_open;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic               w_mem_we;
  rgb444_t            w_mem_wdata;

  logic               r_slot_d;
  logic               r_de_d1;
  logic               r_de_d2;
  rgb444_t            r_pix;

  assign w_rd_slot = disp_enbl && (h_coord[SCALE_LOG2-1:0] == '0);
  assign w_rd_addr = ADDR_W'(fb_read_addr(h_coord, v_coord, FB_W, SCALE_LOG2));

  assign bus.wr_ready = !w_fifo_full && w_wr_open;
  assign w_fifo_push  = bus.wr_valid && bus.wr_ready;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (w_fifo_push),
    .din    ({bus.wr_addr, bus.wr_data}),
    .pop    (w_fifo_pop),
    .dout   (w_fifo_dout),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  assign {w_head_addr, w_head_data} = w_fifo_dout;
  // Out-of-range entries still occupy a slot, they just never strobe the RAM.
  assign w_head_ok = (32'(w_head_addr) < 32'(FB_WORDS));

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  clr_state_t        r_clr_state;
  clr_state_t        w_clr_next;
  logic [ADDR_W-1:0] r_clr_addr;
  rgb444_t           r_clr_color;
  logic              w_clr_last;

  assign w_clr_active = (r_clr_state == CLR_CLEAR);
  assign w_clr_addr   = r_clr_addr;
  assign w_clr_data   = r_clr_color;
  assign w_wr_open    = (r_clr_state == CLR_IDLE);
  assign clear_busy   = (r_clr_state != CLR_IDLE);
  assign w_clr_last   = (r_clr_addr == C_LAST_ADDR);

  // Clear engine next state; requests while busy fall through unchanged
  always_comb begin
    w_clr_next = r_clr_state;
    case (r_clr_state)
      CLR_IDLE:  if (clear_req) w_clr_next = CLR_DRAIN; else w_clr_next = CLR_IDLE;
      CLR_DRAIN: if (w_fifo_empty) w_clr_next = CLR_CLEAR; else w_clr_next = CLR_DRAIN;
      CLR_CLEAR: if ((w_gnt == GNT_CLEAR) && w_clr_last) w_clr_next = CLR_IDLE;
                 else w_clr_next = CLR_CLEAR;
      default:   w_clr_next = CLR_IDLE;
    endcase
  end

  // Clear engine state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_clr_state <= CLR_IDLE;
    else         r_clr_state <= w_clr_next;
  end

  // Clear address walk and colour captured at the accepted request
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      if ((r_clr_state == CLR_IDLE) && clear_req) r_clr_color <= clear_color;
      if (w_gnt == GNT_CLEAR) r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
    end
  end
`else
  assign w_clr_active = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
  assign w_wr_open    = 1'b1;
`endif

  // Port grant: display read, then clear engine, then FIFO head
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_rd_slot)            w_gnt = GNT_READ;
    else if (w_clr_active)    w_gnt = GNT_CLEAR;
    else if (!w_fifo_empty)   w_gnt = GNT_FIFO;
    else                      w_gnt = GNT_NONE;
  end

  // RAM port mux driven by the grant
  always_comb begin
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    w_fifo_pop  = 1'b0;
    case (w_gnt)
      GNT_READ: w_mem_addr = w_rd_addr;
      GNT_CLEAR: begin
        w_mem_addr  = w_clr_addr;
        w_mem_we    = 1'b1;
        w_mem_wdata = w_clr_data;
      end
      GNT_FIFO: begin
        w_fifo_pop = 1'b1;
        if (w_head_ok) begin
          w_mem_addr  = w_head_addr;
          w_mem_we    = 1'b1;
          w_mem_wdata = w_head_data;
        end else begin
          w_mem_addr  = '0;
          w_mem_we    = 1'b0;
          w_mem_wdata = '0;
        end
      end
      default: w_mem_addr = '0;
    endcase
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;

  // Readout pipeline: RAM data lands one cycle after the slot, pixel shows the cycle after
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_slot_d <= 1'b0;
      r_de_d1  <= 1'b0;
      r_de_d2  <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_slot_d <= w_rd_slot;
      r_de_d1  <= disp_enbl;
      r_de_d2  <= r_de_d1;
      if (r_slot_d) r_pix <= bus.mem_rdata;
    end
  end

  assign pix_r  = r_de_d2 ? r_pix.r : 4'h0;
  assign pix_g  = r_de_d2 ? r_pix.g : 4'h0;
  assign pix_b  = r_de_d2 ? r_pix.b : 4'h0;
  assign pix_de = r_de_d2;

endmodule
